// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU ops, forwarding selects,
// and the iterative multiplier's state type.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'b00,
    MULT_BUSY = 2'b01,
    MULT_DONE = 2'b10
  } mult_state_t;

endpackage

// File: rtl/mult_iter.sv
// Iterative 32-cycle shift-add multiplier (low 32 bits of the product).
// busy covers the start cycle plus the 32 iterations; done is a one-cycle pulse.
module mult_iter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  mult_state_t state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] mcand_q, mplier_q, prod_q;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      MULT_IDLE: if (start) begin
        busy    = 1'b1;
        state_d = MULT_BUSY;
      end
      MULT_BUSY: begin
        busy = 1'b1;
        if (cnt_q == 6'd31) state_d = MULT_DONE;
      end
      MULT_DONE: begin
        done    = 1'b1;
        state_d = MULT_IDLE;
      end
      default: state_d = MULT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MULT_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MULT_IDLE && start) begin
        mcand_q  <= a;
        mplier_q <= b;
        prod_q   <= '0;
        cnt_q    <= '0;
      end else if (state_q == MULT_BUSY) begin
        // Bits shifted past 31 are dropped: only the low word is kept.
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 6'd1;
      end
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/instr_execute.sv
// MIPS EX stage: forwarding muxes, ALU, and the EX/MEM pipeline register.
// Define MULT_EXEC_EN to build the iterative multiplier and its stall.
module instr_execute
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_to_reg_wr,
  input  logic        id_ex_mem_wr_en,
  input  logic        id_ex_alu_src_sel,
  input  logic        id_ex_reg_wr_en,
  input  logic        id_ex_mult_start,
  input  logic [2:0]  id_ex_alu_ctrl,
  input  logic [4:0]  id_ex_reg_wr_addr,
  input  logic [4:0]  id_ex_rs,
  input  logic [4:0]  id_ex_rt,
  input  logic [31:0] id_ex_reg_data1,
  input  logic [31:0] id_ex_reg_data2,
  input  logic [31:0] id_ex_sign_imm_ext,
  input  logic [1:0]  forwardA_ex,
  input  logic [1:0]  forwardB_ex,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] wb_result,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_reg_wr_addr,
  output logic        ex_mem_to_reg_wr_c,
  output logic        ex_reg_wr_en_c,
  output logic        ex_stall,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_wr_data,
  output logic [4:0]  ex_mem_reg_wr_addr,
  output logic        ex_mem_reg_wr_en,
  output logic        ex_mem_mem_to_reg_wr,
  output logic        ex_mem_mem_wr_en
);

  logic [31:0] src_a, fwd_b, src_b, alu_out, ex_result;
  logic        mult_done;
  logic [31:0] mult_product;

  assign ex_rs              = id_ex_rs;
  assign ex_rt              = id_ex_rt;
  assign ex_reg_wr_addr     = id_ex_reg_wr_addr;
  assign ex_mem_to_reg_wr_c = id_ex_mem_to_reg_wr;
  assign ex_reg_wr_en_c     = id_ex_reg_wr_en;

  always_comb begin
    case (forwardA_ex)
      FWD_WB:  src_a = wb_result;
      FWD_MEM: src_a = mem_alu_result;
      default: src_a = id_ex_reg_data1;
    endcase
    case (forwardB_ex)
      FWD_WB:  fwd_b = wb_result;
      FWD_MEM: fwd_b = mem_alu_result;
      default: fwd_b = id_ex_reg_data2;
    endcase
  end

  assign src_b = id_ex_alu_src_sel ? id_ex_sign_imm_ext : fwd_b;

  always_comb begin
    case (id_ex_alu_ctrl)
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_SLT: alu_out = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_out = '0;
    endcase
  end

`ifdef MULT_EXEC_EN
  mult_iter u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (id_ex_mult_start),
    .a       (src_a),
    .b       (fwd_b),
    .busy    (ex_stall),
    .done    (mult_done),
    .product (mult_product)
  );
`else
  logic unused_mult;
  assign unused_mult  = id_ex_mult_start;
  assign ex_stall     = 1'b0;
  assign mult_done    = 1'b0;
  assign mult_product = '0;
`endif

  assign ex_result = mult_done ? mult_product : alu_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_alu_result    <= '0;
      ex_mem_wr_data       <= '0;
      ex_mem_reg_wr_addr   <= '0;
      ex_mem_reg_wr_en     <= 1'b0;
      ex_mem_mem_to_reg_wr <= 1'b0;
      ex_mem_mem_wr_en     <= 1'b0;
    end else if (ex_stall) begin
      // Bubble while the multiplier holds the front of the pipe.
      ex_mem_alu_result    <= '0;
      ex_mem_wr_data       <= '0;
      ex_mem_reg_wr_addr   <= '0;
      ex_mem_reg_wr_en     <= 1'b0;
      ex_mem_mem_to_reg_wr <= 1'b0;
      ex_mem_mem_wr_en     <= 1'b0;
    end else begin
      ex_mem_alu_result    <= ex_result;
      ex_mem_wr_data       <= fwd_b;
      ex_mem_reg_wr_addr   <= id_ex_reg_wr_addr;
      ex_mem_reg_wr_en     <= id_ex_reg_wr_en;
      ex_mem_mem_to_reg_wr <= id_ex_mem_to_reg_wr;
      ex_mem_mem_wr_en     <= id_ex_mem_wr_en;
    end
  end

endmodule

// File: tb/tb_instr_execute.sv
// Directed bench for instr_execute; multiplier steps run only when MULT_EXEC_EN is defined.
module tb_instr_execute;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ex_mem_to_reg_wr, id_ex_mem_wr_en, id_ex_alu_src_sel, id_ex_reg_wr_en;
  logic        id_ex_mult_start;
  logic [2:0]  id_ex_alu_ctrl;
  logic [4:0]  id_ex_reg_wr_addr, id_ex_rs, id_ex_rt;
  logic [31:0] id_ex_reg_data1, id_ex_reg_data2, id_ex_sign_imm_ext;
  logic [1:0]  forwardA_ex, forwardB_ex;
  logic [31:0] mem_alu_result, wb_result;
  logic [4:0]  ex_rs, ex_rt, ex_reg_wr_addr;
  logic        ex_mem_to_reg_wr_c, ex_reg_wr_en_c, ex_stall;
  logic [31:0] ex_mem_alu_result, ex_mem_wr_data;
  logic [4:0]  ex_mem_reg_wr_addr;
  logic        ex_mem_reg_wr_en, ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en;

  int passed = 0;
  int total  = 0;

  instr_execute dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_to_reg_wr(id_ex_mem_to_reg_wr), .id_ex_mem_wr_en(id_ex_mem_wr_en),
    .id_ex_alu_src_sel(id_ex_alu_src_sel), .id_ex_reg_wr_en(id_ex_reg_wr_en),
    .id_ex_mult_start(id_ex_mult_start), .id_ex_alu_ctrl(id_ex_alu_ctrl),
    .id_ex_reg_wr_addr(id_ex_reg_wr_addr), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_reg_data1(id_ex_reg_data1), .id_ex_reg_data2(id_ex_reg_data2),
    .id_ex_sign_imm_ext(id_ex_sign_imm_ext),
    .forwardA_ex(forwardA_ex), .forwardB_ex(forwardB_ex),
    .mem_alu_result(mem_alu_result), .wb_result(wb_result),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_wr_addr(ex_reg_wr_addr),
    .ex_mem_to_reg_wr_c(ex_mem_to_reg_wr_c), .ex_reg_wr_en_c(ex_reg_wr_en_c),
    .ex_stall(ex_stall),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_mem_reg_wr_addr(ex_mem_reg_wr_addr), .ex_mem_reg_wr_en(ex_mem_reg_wr_en),
    .ex_mem_mem_to_reg_wr(ex_mem_mem_to_reg_wr), .ex_mem_mem_wr_en(ex_mem_mem_wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex_mem_zero(input string tag);
    chk({tag, " alu"},    ex_mem_alu_result, 32'd0);
    chk({tag, " wdata"},  ex_mem_wr_data, 32'd0);
    chk({tag, " addr"},   {27'd0, ex_mem_reg_wr_addr}, 32'd0);
    chk({tag, " ctrl"},   {29'd0, ex_mem_reg_wr_en, ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en}, 32'd0);
    chk({tag, " stall"},  {31'd0, ex_stall}, 32'd0);
  endtask

`ifdef MULT_EXEC_EN
  // Caller has set up a multiply and is in its start cycle.
  task automatic run_mult(input string tag, input logic [31:0] exp);
    int stall_cycles;
    int bubble_bad;
    stall_cycles = 0;
    bubble_bad   = 0;
    for (int k = 0; k < 40 && ex_stall; k++) begin
      stall_cycles++;
      step();
      if (ex_stall && ex_mem_reg_wr_en) bubble_bad++;
    end
    chk({tag, " stall cycles"}, stall_cycles, 32'd33);
    chk({tag, " bubbles"}, bubble_bad, 32'd0);
    chk({tag, " bubble wr_en"}, {31'd0, ex_mem_reg_wr_en}, 32'd0);
    step();
    id_ex_mult_start = 1'b0;
    chk({tag, " result"}, ex_mem_alu_result, exp);
    chk({tag, " wr_en"}, {31'd0, ex_mem_reg_wr_en}, 32'd1);
    chk({tag, " addr"}, {27'd0, ex_mem_reg_wr_addr}, 32'd9);
    chk({tag, " idle stall"}, {31'd0, ex_stall}, 32'd0);
  endtask
`endif

  initial begin
    reset = 1'b0;
    id_ex_mem_to_reg_wr = 0; id_ex_mem_wr_en = 0; id_ex_alu_src_sel = 0;
    id_ex_reg_wr_en = 0; id_ex_mult_start = 0; id_ex_alu_ctrl = ALU_ADD;
    id_ex_reg_wr_addr = 0; id_ex_rs = 0; id_ex_rt = 0;
    id_ex_reg_data1 = 0; id_ex_reg_data2 = 0; id_ex_sign_imm_ext = 0;
    forwardA_ex = FWD_RF; forwardB_ex = FWD_RF;
    mem_alu_result = 0; wb_result = 0;
    step();
    chk_ex_mem_zero("reset");
    reset = 1'b1;
    step();

    // sub 7-5, plus combinational pass-throughs
    id_ex_reg_data1 = 7; id_ex_reg_data2 = 5; id_ex_alu_ctrl = ALU_SUB;
    id_ex_reg_wr_en = 1; id_ex_reg_wr_addr = 5'd3; id_ex_rs = 5'd1; id_ex_rt = 5'd2;
    id_ex_mem_to_reg_wr = 1;
    #1;
    chk("pass rs", {27'd0, ex_rs}, 32'd1);
    chk("pass rt", {27'd0, ex_rt}, 32'd2);
    chk("pass wa", {27'd0, ex_reg_wr_addr}, 32'd3);
    chk("pass ctl", {30'd0, ex_mem_to_reg_wr_c, ex_reg_wr_en_c}, 32'd3);
    step();
    chk("sub", ex_mem_alu_result, 32'd2);
    chk("sub wdata", ex_mem_wr_data, 32'd5);
    chk("sub addr", {27'd0, ex_mem_reg_wr_addr}, 32'd3);
    chk("sub ctrl", {29'd0, ex_mem_reg_wr_en, ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en}, 32'b110);

    // signed slt both ways
    id_ex_mem_to_reg_wr = 0;
    id_ex_reg_data1 = 32'hFFFF_FFFF; id_ex_reg_data2 = 1; id_ex_alu_ctrl = ALU_SLT;
    step();
    chk("slt -1<1", ex_mem_alu_result, 32'd1);
    id_ex_reg_data1 = 1; id_ex_reg_data2 = 32'hFFFF_FFFF;
    step();
    chk("slt 1<-1", ex_mem_alu_result, 32'd0);

    // add wrap, and/or, unused op
    id_ex_reg_data1 = 32'hFFFF_FFFF; id_ex_reg_data2 = 1; id_ex_alu_ctrl = ALU_ADD;
    step();
    chk("add wrap", ex_mem_alu_result, 32'd0);
    id_ex_reg_data1 = 32'hF0F0_00FF; id_ex_reg_data2 = 32'h0FF0_0F0F; id_ex_alu_ctrl = ALU_AND;
    step();
    chk("and", ex_mem_alu_result, 32'h00F0_000F);
    id_ex_alu_ctrl = ALU_OR;
    step();
    chk("or", ex_mem_alu_result, 32'hFFF0_0FFF);
    id_ex_alu_ctrl = 3'b100;
    step();
    chk("op100", ex_mem_alu_result, 32'd0);

    // forwarding: A from MEM, B from WB, immediate operand
    forwardA_ex = FWD_MEM; mem_alu_result = 32'h100;
    id_ex_alu_src_sel = 1; id_ex_sign_imm_ext = 32'hFFFF_FFFC; id_ex_alu_ctrl = ALU_ADD;
    forwardB_ex = FWD_WB; wb_result = 32'hABCD; id_ex_mem_wr_en = 1;
    step();
    chk("fwd add", ex_mem_alu_result, 32'h0000_00FC);
    chk("fwd wdata", ex_mem_wr_data, 32'h0000_ABCD);
    chk("fwd memwr", {31'd0, ex_mem_mem_wr_en}, 32'd1);

    // select 11 behaves as register file
    forwardA_ex = 2'b11; forwardB_ex = 2'b11; id_ex_alu_src_sel = 0;
    id_ex_reg_data1 = 32'd9; id_ex_reg_data2 = 32'd4; id_ex_alu_ctrl = ALU_SUB;
    step();
    chk("fwd11", ex_mem_alu_result, 32'd5);
    chk("fwd11 wdata", ex_mem_wr_data, 32'd4);

    // async reset mid-stream, no clock edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_ex_mem_zero("async reset");
    @(negedge clk);
    reset = 1'b1;
    id_ex_mem_wr_en = 0; forwardA_ex = FWD_RF; forwardB_ex = FWD_RF;
    step();

`ifdef MULT_EXEC_EN
    id_ex_reg_data1 = 32'h0001_0000; id_ex_reg_data2 = 32'h0003_0001;
    id_ex_alu_ctrl = ALU_ADD; id_ex_mult_start = 1; id_ex_reg_wr_addr = 5'd9;
    id_ex_reg_wr_en = 1;
    #1;
    chk("mul start stall", {31'd0, ex_stall}, 32'd1);
    run_mult("mul", 32'h0001_0000);

    // abort at iteration 10, then reissue
    id_ex_mult_start = 1; id_ex_reg_data1 = 32'd1234; id_ex_reg_data2 = 32'd5678;
    for (int k = 0; k < 11; k++) step();
    chk("abort busy", {31'd0, ex_stall}, 32'd1);
    reset = 1'b0;
    #1;
    chk_ex_mem_zero("abort");
    reset = 1'b1;
    #1;
    chk("reissue stall", {31'd0, ex_stall}, 32'd1);
    run_mult("reissue", 32'd7006652);
`else
    id_ex_mult_start = 1; id_ex_alu_ctrl = ALU_ADD;
    id_ex_reg_data1 = 3; id_ex_reg_data2 = 4; id_ex_reg_wr_addr = 5'd9; id_ex_reg_wr_en = 1;
    #1;
    chk("nomul stall", {31'd0, ex_stall}, 32'd0);
    step();
    chk("nomul add", ex_mem_alu_result, 32'd7);
    chk("nomul wr_en", {31'd0, ex_mem_reg_wr_en}, 32'd1);
    step();
    chk("nomul stall2", {31'd0, ex_stall}, 32'd0);
    chk("nomul add2", ex_mem_alu_result, 32'd7);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
